// File: rtl/uart_resp_checker_pkg.sv
// Shared types for uart_resp_checker: FSM state encodings and result codes.
// The tx sender state type is only used when UART_CHK_CMD_EN is defined.
package uart_resp_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RECV = 2'd2,
    ST_DONE = 2'd3
  } chk_state_e;

  typedef enum logic {
    TX_IDLE   = 1'b0,
    TX_ACTIVE = 1'b1
  } tx_state_e;

  localparam logic [1:0] RES_NONE     = 2'd0;
  localparam logic [1:0] RES_PASS     = 2'd1;
  localparam logic [1:0] RES_MISMATCH = 2'd2;
  localparam logic [1:0] RES_TIMEOUT  = 2'd3;

endpackage

// File: rtl/uart_resp_checker_byte_sender.sv
// uart_byte_sender: shifts out a CMD_LENGTH-byte command, MSB byte first, on a ready/valid tx port.
// Only built when UART_CHK_CMD_EN is defined.
`ifdef UART_CHK_CMD_EN
module uart_byte_sender
  import uart_resp_checker_pkg::*;
#(
  parameter int CMD_LENGTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load,
  input  logic                    i_abort,
  input  logic [8*CMD_LENGTH-1:0] i_cmd,
  output logic [7:0]              o_tx_data,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  output logic                    o_last
);
  localparam int CW = $clog2(CMD_LENGTH) + 1;

  tx_state_e               r_state;
  tx_state_e               w_state_nxt;
  logic [8*CMD_LENGTH-1:0] r_shift;
  logic [CW-1:0]           r_left;
  logic                    w_hs;

  // tx_valid is held from load until the byte is taken; data never changes while waiting.
  assign o_tx_valid = (r_state == TX_ACTIVE);
  assign o_tx_data  = r_shift[8*CMD_LENGTH-1 -: 8];
  assign w_hs       = o_tx_valid && i_tx_ready;
  assign o_last     = w_hs && (r_left == CW'(1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      TX_IDLE:   if (i_load) w_state_nxt = TX_ACTIVE;
      TX_ACTIVE: if (i_abort || o_last) w_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= TX_IDLE;
      r_shift <= '0;
      r_left  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == TX_IDLE && i_load) begin
        r_shift <= i_cmd;
        r_left  <= CW'(CMD_LENGTH);
      end else if (w_hs) begin
        r_shift <= r_shift << 8;
        r_left  <= r_left - CW'(1);
      end
    end
  end

endmodule
`endif

// File: rtl/uart_resp_checker.sv
// uart_resp_checker: collects MSG_LENGTH bytes from a UART rx stream and compares them to an
// expected string, reporting pass / mismatch / timeout. UART_CHK_CMD_EN adds a command send phase.
module uart_resp_checker
  import uart_resp_checker_pkg::*;
#(
  parameter int MSG_LENGTH     = 4,
`ifdef UART_CHK_CMD_EN
  parameter int CMD_LENGTH     = 4,
`endif
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [8*MSG_LENGTH-1:0]     expected,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  output logic                        rx_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic                        fail_mismatch,
  output logic                        fail_timeout,
  output logic [$clog2(MSG_LENGTH):0] mismatch_idx,
  output logic [8*MSG_LENGTH-1:0]     msg,
  output logic [CNT_WIDTH-1:0]        cycles,
`ifdef UART_CHK_CMD_EN
  input  logic [8*CMD_LENGTH-1:0]     cmd,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
`endif
  output logic [1:0]                  dbg_state
);
  localparam int                   MSG_W    = 8 * MSG_LENGTH;
  localparam int                   IDX_W    = $clog2(MSG_LENGTH) + 1;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(MSG_LENGTH - 1);
  localparam logic [IDX_W-1:0]     FULL_IDX = IDX_W'(MSG_LENGTH);
  localparam logic [CNT_WIDTH-1:0] TO_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  chk_state_e           r_state;
  chk_state_e           w_state_nxt;
  logic [MSG_W-1:0]     r_exp;
  logic [MSG_W-1:0]     r_msg;
  logic [IDX_W-1:0]     r_byte_idx;
  logic [IDX_W-1:0]     r_mismatch_idx;
  logic                 r_mis_seen;
  logic [CNT_WIDTH-1:0] r_count;
  logic [1:0]           r_result;
  logic w_start, w_busy, w_hs, w_last_byte, w_byte_ne, w_timeout, w_to_done;

  // Ready/valid: a byte transfers on a posedge where valid && ready; ready depends only on state,
  // never on valid, and the sender may not withdraw valid or change data until the transfer.
  assign w_start     = (r_state == ST_IDLE) && start;
  assign w_busy      = (r_state == ST_SEND) || (r_state == ST_RECV);
  assign rx_ready    = (r_state == ST_RECV);
  assign w_hs        = rx_ready && rx_valid;
  assign w_last_byte = (r_byte_idx == LAST_IDX);
  // r_exp shifts left per byte, so its top byte is always the one due next.
  assign w_byte_ne   = (rx_data != r_exp[MSG_W-1 -: 8]);
  assign w_timeout   = (r_count == TO_LAST);
  assign w_to_done   = w_busy && (w_state_nxt == ST_DONE);

`ifdef UART_CHK_CMD_EN
  logic w_tx_last;
  logic w_tx_abort;
  assign w_tx_abort = (r_state == ST_SEND) && w_timeout;

  uart_byte_sender #(.CMD_LENGTH(CMD_LENGTH)) u_sender (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_start),
    .i_abort    (w_tx_abort),
    .i_cmd      (cmd),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (tx_ready),
    .o_last     (w_tx_last)
  );
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
`ifdef UART_CHK_CMD_EN
          w_state_nxt = ST_SEND;
`else
          w_state_nxt = ST_RECV;
`endif
        end
      end
      ST_SEND: begin
`ifdef UART_CHK_CMD_EN
        if (w_timeout)      w_state_nxt = ST_DONE;
        else if (w_tx_last) w_state_nxt = ST_RECV;
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      // A final byte on the timeout cycle still completes the check.
      ST_RECV: if ((w_hs && w_last_byte) || w_timeout) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_exp          <= '0;
      r_msg          <= '0;
      r_byte_idx     <= '0;
      r_mismatch_idx <= '0;
      r_mis_seen     <= 1'b0;
      r_count        <= '0;
      r_result       <= RES_NONE;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_exp          <= expected;
        r_msg          <= '0;
        r_byte_idx     <= '0;
        r_mismatch_idx <= FULL_IDX;
        r_mis_seen     <= 1'b0;
        r_count        <= '0;
        r_result       <= RES_NONE;
      end else begin
        // The count stops on the cycle that leaves for DONE, so it reads as start-to-done.
        if (w_busy && !w_to_done) r_count <= r_count + CNT_WIDTH'(1);
        if (w_hs) begin
          r_msg      <= (r_msg << 8) | MSG_W'(rx_data);
          r_exp      <= r_exp << 8;
          r_byte_idx <= r_byte_idx + IDX_W'(1);
          if (w_byte_ne && !r_mis_seen) begin
            r_mis_seen     <= 1'b1;
            r_mismatch_idx <= r_byte_idx;
          end
        end
        if (w_to_done) begin
          if (w_hs && w_last_byte) r_result <= (r_mis_seen || w_byte_ne) ? RES_MISMATCH : RES_PASS;
          else                     r_result <= RES_TIMEOUT;
        end
      end
    end
  end

  assign busy          = w_busy;
  assign done          = (r_state == ST_DONE);
  assign pass          = (r_result == RES_PASS);
  assign fail_mismatch = (r_result == RES_MISMATCH);
  assign fail_timeout  = (r_result == RES_TIMEOUT);
  assign mismatch_idx  = r_mismatch_idx;
  assign msg           = r_msg;
  assign cycles        = r_count;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_uart_resp_checker.sv
// Directed bench for uart_resp_checker (MSG_LENGTH=4, TIMEOUT_CYCLES=100); the command
// send scenario is compiled in when UART_CHK_CMD_EN is defined.
module tb_uart_resp_checker;
  localparam int MSG_LENGTH     = 4;
  localparam int TIMEOUT_CYCLES = 100;
  localparam int CNT_WIDTH      = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] expected = '0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready, busy, done, pass, fail_mismatch, fail_timeout;
  logic [2:0]  mismatch_idx;
  logic [31:0] msg;
  logic [31:0] cycles;
  logic [1:0]  dbg_state;
`ifdef UART_CHK_CMD_EN
  logic [31:0] cmd = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_q[$];
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int cyc = 0;
  int s_cyc = 0;

  uart_resp_checker #(
    .MSG_LENGTH     (MSG_LENGTH),
`ifdef UART_CHK_CMD_EN
    .CMD_LENGTH     (4),
`endif
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .expected      (expected),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .fail_mismatch (fail_mismatch),
    .fail_timeout  (fail_timeout),
    .mismatch_idx  (mismatch_idx),
    .msg           (msg),
    .cycles        (cycles),
`ifdef UART_CHK_CMD_EN
    .cmd           (cmd),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
`endif
    .dbg_state     (dbg_state)
  );

  // clock / cycle counter / monitors
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_cnt++;
`ifdef UART_CHK_CMD_EN
  always @(negedge clk) if (tx_valid && tx_ready) tx_q.push_back(tx_data);
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic do_start(input logic [31:0] e);
    start = 1'b1;
    expected = e;
    @(posedge clk); #1;
    start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    rx_valid = 1'b1;
    rx_data = b;
    while (!rx_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 200) begin
      checks++; errors++;
      $display("FAIL send_byte_timeout byte=%02h rx_ready never high", b);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(t[31:24]);
      t = t << 8;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL wait_done no done pulse within 400 cycles");
    end
  endtask

  // scenarios
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%0b exp=0", done); end
    checks++; if ({pass, fail_mismatch, fail_timeout} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%03b exp=000", {pass, fail_mismatch, fail_timeout}); end
    checks++; if (msg !== 32'h0) begin errors++; $display("FAIL rst_msg got=%08h exp=0", msg); end
    checks++; if (cycles !== 32'd0) begin errors++; $display("FAIL rst_cycles got=%0d exp=0", cycles); end
    checks++; if (mismatch_idx !== 3'd0) begin errors++; $display("FAIL rst_idx got=%0d exp=0", mismatch_idx); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rst_rx_ready got=%0b exp=0", rx_ready); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_pass();
    logic [7:0] b[4];
    int d0;
    b = '{8'h31, 8'h35, 8'h31, 8'h3E};
    d0 = done_cnt;
    do_start(32'h3135313E);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pass_busy got=%0b exp=1", busy); end
    for (int i = 0; i < 4; i++) begin
      repeat (i % 2 + 1) begin @(posedge clk); #1; end
      send_byte(b[i]);
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL pass_done got=%0b exp=1", done); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL pass_pass got=%0b exp=1", pass); end
    checks++; if ({fail_mismatch, fail_timeout} !== 2'b00) begin errors++; $display("FAIL pass_fails got=%02b exp=00", {fail_mismatch, fail_timeout}); end
    checks++; if (msg !== 32'h3135313E) begin errors++; $display("FAIL pass_msg got=%08h exp=3135313e", msg); end
    checks++; if (mismatch_idx !== 3'd4) begin errors++; $display("FAIL pass_idx got=%0d exp=4", mismatch_idx); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL pass_done_low got=%0b exp=0", done); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL pass_held got=%0b exp=1", pass); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL pass_done_pulses got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_mismatch();
    do_start(32'h3135313E);
    send_word(32'h3135303E);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mis_done got=%0b exp=1", done); end
    checks++; if (fail_mismatch !== 1'b1) begin errors++; $display("FAIL mis_flag got=%0b exp=1", fail_mismatch); end
    checks++; if ({pass, fail_timeout} !== 2'b00) begin errors++; $display("FAIL mis_others got=%02b exp=00", {pass, fail_timeout}); end
    checks++; if (mismatch_idx !== 3'd2) begin errors++; $display("FAIL mis_idx got=%0d exp=2", mismatch_idx); end
    checks++; if (msg !== 32'h3135303E) begin errors++; $display("FAIL mis_msg got=%08h exp=3135303e", msg); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    do_start(32'h3135313E);
    send_byte(8'h31);
    send_byte(8'h35);
    wait_done();
    checks++; if (cyc - s_cyc !== 100) begin errors++; $display("FAIL to_latency got=%0d exp=100", cyc - s_cyc); end
    checks++; if (fail_timeout !== 1'b1) begin errors++; $display("FAIL to_flag got=%0b exp=1", fail_timeout); end
    checks++; if ({pass, fail_mismatch} !== 2'b00) begin errors++; $display("FAIL to_others got=%02b exp=00", {pass, fail_mismatch}); end
    checks++; if (cycles !== 32'd99) begin errors++; $display("FAIL to_cycles got=%0d exp=99", cycles); end
    checks++; if (msg !== 32'h00003135) begin errors++; $display("FAIL to_msg got=%08h exp=00003135", msg); end
    checks++; if (mismatch_idx !== 3'd4) begin errors++; $display("FAIL to_idx got=%0d exp=4", mismatch_idx); end
    @(posedge clk); #1;
  endtask

  task automatic test_last_byte_at_timeout();
    int n;
    do_start(32'h3135313E);
    send_byte(8'h31);
    send_byte(8'h35);
    send_byte(8'h31);
    n = 0;
    while (cyc - s_cyc < 99 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL edge_busy got=%0b exp=1", busy); end
    rx_valid = 1'b1;
    rx_data = 8'h3E;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL edge_done got=%0b exp=1", done); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL edge_pass got=%0b exp=1", pass); end
    checks++; if (fail_timeout !== 1'b0) begin errors++; $display("FAIL edge_timeout got=%0b exp=0", fail_timeout); end
    checks++; if (cycles !== 32'd99) begin errors++; $display("FAIL edge_cycles got=%0d exp=99", cycles); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int d0;
    do_start(32'h3135313E);
    send_byte(8'h31);
    send_byte(8'h35);
    d0 = done_cnt;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if ({busy, done, rx_ready} !== 3'b000) begin errors++; $display("FAIL rmid_ctrl got=%03b exp=000", {busy, done, rx_ready}); end
    checks++; if (msg !== 32'h0) begin errors++; $display("FAIL rmid_msg got=%08h exp=0", msg); end
    checks++; if (cycles !== 32'd0) begin errors++; $display("FAIL rmid_cycles got=%0d exp=0", cycles); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rmid_state got=%0d exp=0", dbg_state); end
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL rmid_no_done got=%0d exp=%0d", done_cnt, d0); end
    do_start(32'h3135313E);
    send_word(32'h3135313E);
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL rmid_pass got=%0b exp=1", pass); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    rx_valid = 1'b1;
    rx_data = 8'h55;
    @(posedge clk); #1;
    checks++; if ({rx_ready, busy} !== 2'b00) begin errors++; $display("FAIL b2b_idle_rx got=%02b exp=00", {rx_ready, busy}); end
    rx_valid = 1'b0;
    do_start(32'h3135313E);
    start = 1'b1;
    expected = 32'hFFFFFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    send_word(32'h3135313E);
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL b2b_busy_start got=%0b exp=1", pass); end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if ({busy, dbg_state} !== 3'b000) begin errors++; $display("FAIL b2b_done_start got=%03b exp=000", {busy, dbg_state}); end
    do_start(32'h3135313E);
    send_word(32'h0035313E);
    checks++; if (fail_mismatch !== 1'b1) begin errors++; $display("FAIL b2b_mis0 got=%0b exp=1", fail_mismatch); end
    checks++; if (mismatch_idx !== 3'd0) begin errors++; $display("FAIL b2b_idx0 got=%0d exp=0", mismatch_idx); end
    @(posedge clk); #1;
  endtask

`ifdef UART_CHK_CMD_EN
  task automatic test_cmd();
    logic [7:0] tx_exp[4];
    int k;
    tx_exp = '{8'h6A, 8'h61, 8'h6C, 8'h20};
    tx_q.delete();
    cmd = 32'h6A616C20;
    tx_ready = 1'b0;
    do_start(32'h3135313E);
    checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL cmd_state got=%0d exp=1", dbg_state); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL cmd_rx_ready got=%0b exp=0", rx_ready); end
    k = 0;
    while (tx_q.size() < 4 && k < 60) begin
      tx_ready = k[0];
      @(posedge clk); #1;
      k++;
    end
    tx_ready = 1'b0;
    checks++; if (tx_q.size() !== 4) begin errors++; $display("FAIL cmd_count got=%0d exp=4", tx_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < tx_q.size()) begin
        checks++; if (tx_q[i] !== tx_exp[i]) begin errors++; $display("FAIL cmd_byte%0d got=%02h exp=%02h", i, tx_q[i], tx_exp[i]); end
      end
    end
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL cmd_recv got=%0b exp=1", rx_ready); end
    send_word(32'h3135313E);
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL cmd_pass got=%0b exp=1", pass); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_pass();
    test_mismatch();
    test_timeout();
    test_last_byte_at_timeout();
    test_reset_mid();
    test_back_to_back();
`ifdef UART_CHK_CMD_EN
    test_cmd();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
